// File: rtl/conv2d_pw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_pw_scheduler
//  Description : Walks one shared 1x1 convolution engine over every
//                (out_ch, in_ch) pair of a layer, in_ch innermost. Each job
//                is tagged with first/last flags for accumulator control.
//                The module pulses once per finished output channel and
//                once when the whole layer is finished.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_pw_scheduler #(
  parameter int IN_CHANNEL  = 1,
  parameter int OUT_CHANNEL = 1,
  parameter int IC_W        = (IN_CHANNEL  > 1) ? $clog2(IN_CHANNEL)  : 1,
  parameter int OC_W        = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            eng_start,
  output logic [IC_W-1:0] eng_in_ch,
  output logic [OC_W-1:0] eng_out_ch,
  output logic            eng_first,
  output logic            eng_last,
  input  logic            eng_done,
  output logic            ch_done,
  output logic [OC_W-1:0] ch_idx,
  output logic            proto_err
);

  localparam logic [IC_W-1:0] c_IC_LAST = IC_W'(IN_CHANNEL - 1);
  localparam logic [OC_W-1:0] c_OC_LAST = OC_W'(OUT_CHANNEL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IC_W-1:0] r_ic;
  logic [IC_W-1:0] w_ic_nxt;
  logic [OC_W-1:0] r_oc;
  logic [OC_W-1:0] w_oc_nxt;
  logic [IC_W-1:0] r_eng_in_ch;
  logic [OC_W-1:0] r_eng_out_ch;
  logic            r_eng_first;
  logic            r_eng_last;
  logic            r_ch_done;
  logic [OC_W-1:0] r_ch_idx;
  logic            r_proto_err;

  logic w_abort;
  logic w_accept;
  logic w_job_done;
  logic w_last_pair;

  // abort only matters mid-layer; in IDLE it merely blocks a start
  assign w_abort     = abort && (r_state != S_IDLE);
  assign w_accept    = start && !abort && (r_state == S_IDLE);
  // abort outranks eng_done, so an aborted job never counts as completed
  assign w_job_done  = eng_done && !abort && (r_state == S_WAIT);
  assign w_last_pair = (r_ic == c_IC_LAST) && (r_oc == c_OC_LAST);

  // State register plus the (in_ch, out_ch) pair counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ic    <= '0;
      r_oc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ic    <= w_ic_nxt;
      r_oc    <= w_oc_nxt;
    end
  end

  // Next-state, counter advance and state-decoded handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ic_nxt    = r_ic;
    w_oc_nxt    = r_oc;
    busy        = 1'b0;
    done        = 1'b0;
    eng_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
          w_ic_nxt    = '0;
          w_oc_nxt    = '0;
        end
      end
      S_ISSUE: begin
        busy        = 1'b1;
        eng_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_job_done) begin
          if (w_last_pair) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
            if (r_ic == c_IC_LAST) begin
              w_ic_nxt = '0;
              w_oc_nxt = r_oc + 1'b1;
            end else begin
              w_ic_nxt = r_ic + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_ic_nxt    = '0;
      w_oc_nxt    = '0;
    end
  end

  // Job descriptor latched when entering ISSUE; holds through WAIT and IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eng_in_ch  <= '0;
      r_eng_out_ch <= '0;
      r_eng_first  <= 1'b0;
      r_eng_last   <= 1'b0;
    end else if (w_state_nxt == S_ISSUE) begin
      r_eng_in_ch  <= w_ic_nxt;
      r_eng_out_ch <= w_oc_nxt;
      r_eng_first  <= (w_ic_nxt == '0);
      r_eng_last   <= (w_ic_nxt == c_IC_LAST);
    end
  end

  // Per-output-channel completion pulse, raised when a last-tagged job ends
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_done <= 1'b0;
      r_ch_idx  <= '0;
    end else begin
      r_ch_done <= w_job_done && r_eng_last;
      if (w_job_done && r_eng_last) begin
        r_ch_idx <= r_oc;
      end
    end
  end

  // Sticky protocol error: a fresh error outranks the clear from a new start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (eng_done && (r_state != S_WAIT)) begin
      r_proto_err <= 1'b1;
    end else if (w_accept) begin
      r_proto_err <= 1'b0;
    end
  end

  assign eng_in_ch  = r_eng_in_ch;
  assign eng_out_ch = r_eng_out_ch;
  assign eng_first  = r_eng_first;
  assign eng_last   = r_eng_last;
  assign ch_done    = r_ch_done;
  assign ch_idx     = r_ch_idx;
  assign proto_err  = r_proto_err;

endmodule
`default_nettype wire
